rounding_pipe: RTL

- Streaming, parametrised fixed-point rescaler for matrix-multiply accumulator outputs. Each lane computes in_data / 2^SHIFT, rounds it, then saturates it to OUT_W bits.
- Sits between the MAC array's accumulator drain and the result buffer.
- Multi-lane, valid/ready handshake, 2-stage pipeline.
- Four run-time rounding modes, signed or unsigned operation, and a saturation event counter.

---
 rtl/rounding_pipe_pkg.sv | 22 ++
 rtl/rounding_pipe_if.sv | 33 +++
 rtl/rounding_lane.sv | 108 ++++++++++
 rtl/rounding_pipe.sv | 115 +++++++++++
 4 files changed

// File: rtl/rounding_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rounding_pkg
// Description : Shared constants and width helper for the rounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package rounding_pkg;

  // Run-time rounding mode encodings
  localparam logic [1:0] RND_TRUNC     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;
  localparam logic [1:0] RND_HALF_AWAY = 2'd3;

  // Width of the rounded intermediate: one spare bit above the shifted
  // value so that the +1 rounding increment can never wrap.
  function automatic int rnd_int_w(input int in_w, input int shift);
    return in_w - shift + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rounding_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : rounding_pipe_if
// Description : Input and output beat handshakes of the rounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface rounding_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int LANES = 4
);
  logic [1:0]             mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;

  // Upstream producer / downstream consumer side
  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Rounding pipeline side
  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/rounding_lane.sv
`default_nettype none
// ============================================================================
// Module      : rounding_lane
// Description : One lane: shift+round into stage 1, clamp+flag into stage 2.
// Revision    : 1.0 - initial release
// ============================================================================
module rounding_lane
  import rounding_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 3,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld1,
  input  logic             ld2,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  lane_in,
  output logic [OUT_W-1:0] lane_out,
  output logic             lane_sat
);

  localparam int W_INT = rnd_int_w(IN_W, SHIFT);
  localparam int MAX_I = (SIGNED != 0) ? (2**(OUT_W-1)) - 1 : (2**OUT_W) - 1;
  localparam int MIN_I = (SIGNED != 0) ? -(2**(OUT_W-1)) : 0;
  // Clamp bounds held one bit wider than r so both domains compare as signed
  localparam logic signed [W_INT:0] MAX_V = (W_INT+1)'(MAX_I);
  localparam logic signed [W_INT:0] MIN_V = (W_INT+1)'(MIN_I);

  logic              sign_bit;
  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              inc;
  logic [W_INT-1:0]  q;
  logic [W_INT-1:0]  r_d;
  logic [W_INT-1:0]  r_q;
  logic signed [W_INT:0] r_ext;
  logic [OUT_W-1:0]  out_d;
  logic [OUT_W-1:0]  out_q;
  logic              sat_d;
  logic              sat_q;

  assign sign_bit = (SIGNED != 0) ? lane_in[IN_W-1] : 1'b0;

  // Sticky covers the bits below the guard bit; there are none for SHIFT == 1
  generate
    if (SHIFT > 1) begin : g_sticky
      assign sticky = |lane_in[SHIFT-2:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

  // Stage-1 next value: floor shift (one extra sign/zero bit) plus rounding increment
  always_comb begin
    q     = {sign_bit, lane_in[IN_W-1:SHIFT]};
    guard = lane_in[SHIFT-1];
    lsb   = lane_in[SHIFT];
    inc   = 1'b0;
    unique case (mode)
      RND_TRUNC:     inc = 1'b0;
      RND_HALF_UP:   inc = guard;
      RND_HALF_EVEN: inc = guard && (sticky || lsb);
      RND_HALF_AWAY: inc = guard && (sticky || !sign_bit);
      default:       inc = 1'b0;
    endcase
    r_d = q + W_INT'(inc);
  end

  // Stage-2 next value: clamp the rounded value into the output range
  always_comb begin
    r_ext = $signed({((SIGNED != 0) ? r_q[W_INT-1] : 1'b0), r_q});
    out_d = r_ext[OUT_W-1:0];
    sat_d = 1'b0;
    if (r_ext > MAX_V) begin
      out_d = MAX_V[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (r_ext < MIN_V) begin
      out_d = MIN_V[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  // Lane registers, each stage loads only when the parent advances it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (ld1) begin
        r_q <= r_d;
      end
      if (ld2) begin
        out_q <= out_d;
        sat_q <= sat_d;
      end
    end
  end

  assign lane_out = out_q;
  assign lane_sat = sat_q;

endmodule
`default_nettype wire

// File: rtl/rounding_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rounding_pipe
// Description : Multi-lane 2-stage round/saturate rescaler with valid/ready
//               handshake and saturated-beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rounding_pipe
  import rounding_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 3,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rounding_pipe_if.slave      bus,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    sat_count
);

  logic             s1_valid_d, s1_valid_q;
  logic             s2_valid_d, s2_valid_q;
  logic             s1_ready, s2_ready;
  logic             ld1, ld2;
  logic             out_fire;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [OUT_W-1:0] lane_out [LANES];
  logic [LANES-1:0] lane_sat;

  // Ready ripples backwards combinationally so a full pipe still streams
  assign s2_ready     = !s2_valid_q || bus.out_ready;
  assign s1_ready     = !s1_valid_q || s2_ready;
  assign bus.in_ready = s1_ready;
  assign ld1          = bus.in_valid && s1_ready;
  assign ld2          = s1_valid_q && s2_ready;
  assign out_fire     = s2_valid_q && bus.out_ready;

  // Stage occupancy; mode is consumed by the lanes at acceptance, so each
  // beat carries its own rounding decision down the pipe
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (ld1) begin
      s1_valid_d = 1'b1;
    end else if (ld2) begin
      s1_valid_d = 1'b0;
    end
    if (ld2) begin
      s2_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Saturated-beat counter: clear wins, otherwise sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire && (|lane_sat) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      rounding_lane #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .SIGNED (SIGNED)
      ) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld1      (ld1),
        .ld2      (ld2),
        .mode     (bus.mode),
        .lane_in  (bus.in_data[i*IN_W +: IN_W]),
        .lane_out (lane_out[i]),
        .lane_sat (lane_sat[i])
      );
    end
  endgenerate

  // Pack lane results onto the output bus
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.out_data[i*OUT_W +: OUT_W] = lane_out[i];
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_sat   = lane_sat;
  assign sat_count     = cnt_q;

endmodule
`default_nettype wire
